slave_in_port_burst: RTL

- Parametrised successor to the single-beat serial slave input port.
- Deserialises bit-serial address and data from a bus master, LSB first.
- Supports fixed-length incrementing bursts and read or write commands.
- Buffers the decoded beats in an internal FIFO, which the slave memory or register side drains through a valid/ready interface.

---
 rtl/slave_bus_pkg.sv | 29 ++
 rtl/slave_rx_fifo.sv | 71 +++++++
 rtl/slave_in_port_burst.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/slave_bus_pkg.sv
// rtl/slave_bus_pkg.sv - shared types and default widths for the burst slave input port
// Purpose: FSM state encoding, FIFO entry layout, default widths and a small helper.
// Ports: none (package).
package slave_bus_pkg;

   localparam int ADDR_WIDTH_DEF = 12;
   localparam int DATA_WIDTH_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_PARITY,
      ST_PUSH
   } state_e;

   // Field order of a FIFO entry; the top packs its parametrised entries
   // in the same {addr, data, write} order.
   typedef struct packed {
      logic [ADDR_WIDTH_DEF-1:0] addr;
      logic [DATA_WIDTH_DEF-1:0] data;
      logic                      write;
   } fifo_entry_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/slave_rx_fifo.sv
// rtl/slave_rx_fifo.sv - synchronous width/depth parametrised FIFO with occupancy count
// Purpose: holds decoded beats until the slave side drains them.
// Ports:
//   clk, reset      clock, async active-high reset (empties the FIFO)
//   push_i          write push_data_i at the tail (ignored when full)
//   push_data_i     entry to write
//   pop_i           drop the head (ignored when empty)
//   head_o          head entry, zero while empty
//   empty_o         no entries held
//   count_o         number of entries held
module slave_rx_fifo #(
   parameter int WIDTH = 21,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      count_q;
   logic [PW:0]      count_d;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && (count_q != (PW+1)'(DEPTH));

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage is not reset; head_o is masked while empty instead.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   assign empty_o = (count_q == '0);
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/slave_in_port_burst.sv
// rtl/slave_in_port_burst.sv - serial burst slave input port with output FIFO
// Purpose: deserialises LSB-first address/data from a bus master, expands bursts
//          into incrementing beats and queues {addr, data, write} entries.
// Optional: define SLAVE_IN_PARITY_EN for an even parity bit after each write
//           beat and the sticky parity_err output.
// Ports:
//   clk, reset                      clock, async active-high reset
//   master_valid                    start request (IDLE) or serial bit valid
//   read_en, write_en, rx_burst     command, sampled at the start handshake
//   rx_address, rx_data             serial address / data bits, LSB first
//   slave_ready                     idle with room for a full burst
//   rx_done, cmd_err                completion / rejected-command pulses
//   out_valid, out_ready            FIFO head handshake
//   out_addr, out_data, out_write   FIFO head contents
//   parity_err                      sticky parity error (SLAVE_IN_PARITY_EN only)
module slave_in_port_burst
   import slave_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int BURST_LEN  = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  master_valid,
   input  logic                  read_en,
   input  logic                  write_en,
   input  logic                  rx_burst,
   input  logic                  rx_address,
   input  logic                  rx_data,
   output logic                  slave_ready,
   output logic                  rx_done,
   output logic                  cmd_err,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_write
`ifdef SLAVE_IN_PARITY_EN
   ,
   output logic                  parity_err
`endif
);

   localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH + 1;
   localparam int BIT_W   = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH) + 1);
   localparam int BEAT_W  = $clog2(BURST_LEN + 1);
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

   state_e              state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [BIT_W-1:0]    bit_cnt_q;
   logic [BEAT_W-1:0]   beats_left_q;
   logic                write_q;
   logic                rx_done_q, rx_done_d;
   logic                cmd_err_q, cmd_err_d;

   logic                start;
   logic                cmd_ok;
   logic                bit_last;
   logic                last_beat;
   logic                latch_cmd;
   logic                addr_shift;
   logic                data_shift;
   logic                beat_done;
   logic                push_en;
   logic                beat_bad;

   logic [ENTRY_W-1:0]  fifo_head;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;

`ifdef SLAVE_IN_PARITY_EN
   logic                par_sample;
   logic                par_bad_q;
   logic                parity_err_q;
`endif

   // Space for a whole burst is reserved before accepting any command,
   // so the FIFO can never overflow mid-transaction.
   assign slave_ready = !reset && (state_q == ST_IDLE) &&
                        (fifo_count <= CNT_W'(FIFO_DEPTH - BURST_LEN));
   assign start       = master_valid && slave_ready;
   assign cmd_ok      = read_en ^ write_en;
   assign last_beat   = (beats_left_q == BEAT_W'(1));

   // Last sampled bit of the current serial field.
   always_comb begin
      bit_last = 1'b0;
      if (state_q == ST_ADDR) begin
         bit_last = master_valid && (bit_cnt_q == BIT_W'(ADDR_WIDTH - 1));
      end else if (state_q == ST_DATA) begin
         bit_last = master_valid && (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));
      end
   end

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start && cmd_ok) state_d = ST_ADDR;
         ST_ADDR: if (bit_last) state_d = write_q ? ST_DATA : ST_PUSH;
`ifdef SLAVE_IN_PARITY_EN
         ST_DATA:   if (bit_last) state_d = ST_PARITY;
         ST_PARITY: if (master_valid) state_d = ST_PUSH;
`else
         ST_DATA:   if (bit_last) state_d = ST_PUSH;
`endif
         ST_PUSH: begin
            if (last_beat)    state_d = ST_IDLE;
            else if (write_q) state_d = ST_DATA;
            else              state_d = ST_PUSH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs / datapath strobes
   always_comb begin
      latch_cmd  = 1'b0;
      cmd_err_d  = 1'b0;
      addr_shift = 1'b0;
      data_shift = 1'b0;
      beat_done  = 1'b0;
      push_en    = 1'b0;
      rx_done_d  = 1'b0;
`ifdef SLAVE_IN_PARITY_EN
      par_sample = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            latch_cmd = start && cmd_ok;
            cmd_err_d = start && !cmd_ok;
         end
         ST_ADDR: addr_shift = master_valid;
         ST_DATA: data_shift = master_valid;
`ifdef SLAVE_IN_PARITY_EN
         ST_PARITY: par_sample = master_valid;
`endif
         ST_PUSH: begin
            beat_done = 1'b1;
            push_en   = !(write_q && beat_bad);
            rx_done_d = last_beat;
         end
         default: ;
      endcase
   end

   // Shift registers, bit/beat counters and the registered pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q       <= '0;
         data_q       <= '0;
         bit_cnt_q    <= '0;
         beats_left_q <= '0;
         write_q      <= 1'b0;
         rx_done_q    <= 1'b0;
         cmd_err_q    <= 1'b0;
      end else begin
         rx_done_q <= rx_done_d;
         cmd_err_q <= cmd_err_d;
         if (latch_cmd) begin
            write_q      <= write_en;
            beats_left_q <= rx_burst ? BEAT_W'(BURST_LEN) : BEAT_W'(1);
            addr_q       <= '0;
            data_q       <= '0;   // reads therefore queue zero data
            bit_cnt_q    <= '0;
         end
         // LSB arrives first: shifting in at the MSB leaves bit i in [i].
         if (addr_shift) addr_q <= {rx_address, addr_q[ADDR_WIDTH-1:1]};
         if (data_shift) data_q <= {rx_data, data_q[DATA_WIDTH-1:1]};
         if (addr_shift || data_shift) begin
            bit_cnt_q <= bit_last ? '0 : bit_cnt_q + 1'b1;
         end
         // Address advances even on a dropped beat; wraps modulo 2^ADDR_WIDTH.
         if (beat_done) begin
            addr_q       <= addr_q + 1'b1;
            beats_left_q <= beats_left_q - 1'b1;
         end
      end
   end

`ifdef SLAVE_IN_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else if (latch_cmd) begin
         par_bad_q <= 1'b0;
      end else if (par_sample) begin
         // Even parity: the extra bit equals the XOR of the beat's data.
         par_bad_q <= (rx_data != ^data_q);
         if (rx_data != ^data_q) parity_err_q <= 1'b1;
      end
   end
   assign beat_bad   = par_bad_q;
   assign parity_err = parity_err_q;
`else
   assign beat_bad = 1'b0;
`endif

   slave_rx_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push_en),
      .push_data_i ({addr_q, data_q, write_q}),
      .pop_i       (out_valid && out_ready),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign out_valid = !fifo_empty;
   assign out_addr  = fifo_head[ENTRY_W-1 -: ADDR_WIDTH];
   assign out_data  = fifo_head[DATA_WIDTH:1];
   assign out_write = fifo_head[0];
   assign rx_done   = rx_done_q;
   assign cmd_err   = cmd_err_q;

endmodule
